// File: rtl/fpga_boot_sequencer.sv
`default_nettype none
// -------------------------------------------------------------------------------
// fpga_boot_sequencer - holds the SoC in reset until lock/button allow, reports exit status. Rev 1.0
// -------------------------------------------------------------------------------
module fpga_boot_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned RESET_HOLD_CYCLES = 64,
  parameter int unsigned SLOW_BLINK_LOG2   = 24,
  parameter int unsigned FAST_BLINK_LOG2   = 21
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        locked_i,
  input  logic        rst_btn_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        soc_rst_no,
  output logic [1:0]  state_o,
  output logic        exit_done_o,
  output logic [31:0] exit_code_o,
  output logic        status_led_o
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic                   lock_meta, lock_s, btn_meta, btn_s, btn_d;
  logic [DW-1:0]          deb_cnt;
  logic [HW-1:0]          hold_cnt, hold_next;
  logic [SLOW_BLINK_LOG2:0] blink_cnt, blink_next;
  logic                   done_next, led_next, abort;
  logic [31:0]            code_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      lock_meta <= locked_i;
      lock_s    <= lock_meta;
      btn_meta  <= rst_btn_i;
      btn_s     <= btn_meta;
    end
  end

  // btn_d only follows btn_s after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_cnt <= '0;
      btn_d   <= 1'b0;
    end else if (btn_s == btn_d) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      btn_d   <= btn_s;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign abort      = !lock_s || btn_d;
  assign blink_next = blink_cnt + 1'b1;

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    done_next  = exit_done_o;
    code_next  = exit_code_o;
    if (abort) begin
      state_next = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          hold_next  = '0;
          state_next = HOLD;
        end
        HOLD: begin
          hold_next = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state_next = RUN;
        end
        RUN: begin
          if (exit_valid_i) begin
            state_next = DONE;
            done_next  = 1'b1;
            code_next  = exit_value_i;
          end
        end
        default: state_next = DONE;
      endcase
    end
    if (state_next == WAIT_LOCK) begin
      hold_next = '0;
      done_next = 1'b0;
      code_next = '0;
    end
    // LED is registered, so it is computed from next-cycle state and counter
    case (state_next)
      WAIT_LOCK: led_next = 1'b0;
      HOLD:      led_next = 1'b1;
      RUN:       led_next = blink_next[SLOW_BLINK_LOG2];
      default:   led_next = code_next[0] ? blink_next[FAST_BLINK_LOG2] : 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= WAIT_LOCK;
      hold_cnt     <= '0;
      blink_cnt    <= '0;
      soc_rst_no   <= 1'b0;
      exit_done_o  <= 1'b0;
      exit_code_o  <= '0;
      status_led_o <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      blink_cnt    <= blink_next;
      soc_rst_no   <= (state_next == RUN) || (state_next == DONE);
      exit_done_o  <= done_next;
      exit_code_o  <= code_next;
      status_led_o <= led_next;
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_fpga_boot_sequencer.sv
`default_nettype none
// -------------------------------------------------------------------------------
// tb_fpga_boot_sequencer - vector table, corner sequences and random run against a reference model. Rev 1.0
// -------------------------------------------------------------------------------
module tb_fpga_boot_sequencer;
  localparam int DEB = 16, HOLDC = 64, SLOW = 5, FAST = 3;

  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b1, btn = 1'b0, ev = 1'b0;
  logic [31:0] evalue = '0;
  logic soc_rst_n, done, led;
  logic [1:0] state;
  logic [31:0] code;

  fpga_boot_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .RESET_HOLD_CYCLES(HOLDC),
    .SLOW_BLINK_LOG2(SLOW), .FAST_BLINK_LOG2(FAST)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .locked_i(locked), .rst_btn_i(btn),
    .exit_valid_i(ev), .exit_value_i(evalue), .soc_rst_no(soc_rst_n),
    .state_o(state), .exit_done_o(done), .exit_code_o(code), .status_led_o(led)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: phases and elapsed-cycle counts, stepped once per edge
  int m_lock_m, m_lock_s, m_btn_m, m_btn_s, m_btn_d, m_run, m_phase, m_held, m_done, m_edges;
  logic [31:0] m_code;

  function automatic void model_reset();
    m_lock_m = 0; m_lock_s = 0; m_btn_m = 0; m_btn_s = 0; m_btn_d = 0; m_run = 0;
    m_phase = 0; m_held = 0; m_done = 0; m_edges = 0; m_code = '0;
  endfunction

  function automatic void model_step();
    bit ab;
    if (!rst_n) begin model_reset(); return; end
    ab = (m_lock_s == 0) || (m_btn_d == 1);
    if (ab) begin
      m_phase = 0; m_done = 0; m_code = '0;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_held = 0; end
        1: begin m_held++; if (m_held == HOLDC) m_phase = 2; end
        2: if (ev) begin m_phase = 3; m_done = 1; m_code = evalue; end
        default: ;
      endcase
    end
    if (m_btn_s != m_btn_d) begin
      m_run++;
      if (m_run == DEB) begin m_btn_d = m_btn_s; m_run = 0; end
    end else m_run = 0;
    m_lock_s = m_lock_m; m_lock_m = int'(locked);
    m_btn_s  = m_btn_m;  m_btn_m  = int'(btn);
    m_edges++;
  endfunction

  function automatic int exp_led();
    case (m_phase)
      0: return 0;
      1: return 1;
      2: return (m_edges >> SLOW) & 1;
      default: return m_code[0] ? ((m_edges >> FAST) & 1) : 1;
    endcase
  endfunction

  task automatic check_model();
    int er;
    er = (m_phase >= 2) ? 1 : 0;
    vectors++;
    if (int'(state) != m_phase || int'(soc_rst_n) != er || int'(done) != m_done ||
        code !== m_code || int'(led) != exp_led()) begin
      miscompares++;
      $display("FAIL model t=%0t: got state=%0d rst_n=%0b done=%0b code=%h led=%0b, want state=%0d rst_n=%0d done=%0d code=%h led=%0d",
               $time, state, soc_rst_n, done, code, led, m_phase, er, m_done, m_code, exp_led());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1 check_model();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit locked; bit btn; bit ev; logic [31:0] val; int cycles;
    int st; int rst; int dn; logic [31:0] cd; int led;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int last_t, toggles;
    logic prev_led;
    int btn_left;

    tbl[0]  = '{1,0,0,0, 3,   1,0,0,0, 1};
    tbl[1]  = '{1,0,0,0, 63,  1,0,0,0, 1};
    tbl[2]  = '{1,0,0,0, 1,   2,1,0,0,-1};
    tbl[3]  = '{1,0,1,0, 1,   3,1,1,0, 1};
    tbl[4]  = '{1,0,1,5, 1,   3,1,1,0, 1};
    tbl[5]  = '{1,0,0,0, 10,  3,1,1,0, 1};
    tbl[6]  = '{1,1,0,0, 18,  3,1,1,0, 1};
    tbl[7]  = '{1,1,0,0, 1,   0,0,0,0, 0};
    tbl[8]  = '{1,1,0,0, 30,  0,0,0,0, 0};
    tbl[9]  = '{1,0,0,0, 18,  0,0,0,0, 0};
    tbl[10] = '{1,0,0,0, 1,   1,0,0,0, 1};
    tbl[11] = '{1,0,0,0, 63,  1,0,0,0, 1};
    tbl[12] = '{1,0,0,0, 1,   2,1,0,0,-1};
    tbl[13] = '{1,0,1,1, 1,   3,1,1,1,-1};

    model_reset();
    tick(); tick();
    chk("reset_state", 32'(state), 0);
    chk("reset_soc_rst", 32'(soc_rst_n), 0);
    chk("reset_done_code_led", {done, led, code[29:0]}, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      locked = tbl[r].locked; btn = tbl[r].btn; ev = tbl[r].ev; evalue = tbl[r].val;
      repeat (tbl[r].cycles) tick();
      vectors++;
      if (int'(state) != tbl[r].st || int'(soc_rst_n) != tbl[r].rst || int'(done) != tbl[r].dn ||
          code !== tbl[r].cd || (tbl[r].led >= 0 && int'(led) != tbl[r].led)) begin
        miscompares++;
        $display("FAIL row%0d: got state=%0d rst_n=%0b done=%0b code=%h led=%0b, want state=%0d rst_n=%0d done=%0d code=%h led=%0d",
                 r, state, soc_rst_n, done, code, led, tbl[r].st, tbl[r].rst, tbl[r].dn, tbl[r].cd, tbl[r].led);
      end
    end
    ev = 1'b0;

    // Fail exit: LED toggles every 8 cycles
    prev_led = led; last_t = -1; toggles = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (led != prev_led) begin
        if (last_t >= 0) chk("fail_blink_period", 32'(t - last_t), 8);
        last_t = t; toggles++;
      end
      prev_led = led;
    end
    chk("fail_blink_toggles", 32'(toggles >= 4), 1);

    // Lock loss from DONE, then again at hold count 40
    locked = 1'b0; tick(); tick();
    chk("lockloss_pre", 32'(state), 3);
    tick();
    chk("lockloss_state", 32'(state), 0);
    chk("lockloss_clear", {soc_rst_n, done, code[29:0]}, 0);
    locked = 1'b1; repeat (3) tick();
    chk("relock_hold", 32'(state), 1);
    repeat (40) tick();
    locked = 1'b0; tick(); tick();
    chk("hold40_pre", 32'(state), 1);
    tick();
    chk("hold40_abort", 32'(state), 0);
    locked = 1'b1; repeat (3) tick();
    chk("rehold", 32'(state), 1);
    repeat (63) tick();
    chk("rehold_full", 32'(state), 1);
    tick();
    chk("rerun", 32'(state), 2);

    // Short button glitches in RUN
    repeat (3) begin
      btn = 1'b1; repeat (10) tick();
      btn = 1'b0; repeat (10) tick();
    end
    chk("glitch_state", 32'(state), 2);
    chk("glitch_rst", 32'(soc_rst_n), 1);

    // Abort on the last HOLD cycle
    locked = 1'b0; repeat (3) tick();
    locked = 1'b1; repeat (3) tick();
    chk("final_hold_entry", 32'(state), 1);
    repeat (61) tick();
    locked = 1'b0; tick(); tick();
    chk("final_hold_pre", 32'(state), 1);
    tick();
    chk("final_hold_abort", 32'(state), 0);
    locked = 1'b1; repeat (67) tick();
    chk("final_hold_rerun", 32'(state), 2);

    // Exit together with abort
    locked = 1'b0; tick(); tick();
    ev = 1'b1; evalue = 32'h7; tick(); ev = 1'b0;
    chk("exit_abort_state", 32'(state), 0);
    chk("exit_abort_done", 32'(done), 0);
    locked = 1'b1; repeat (67) tick();
    chk("exit_abort_rerun", 32'(state), 2);

    // Asynchronous reset from DONE
    ev = 1'b1; evalue = 32'h2; tick(); ev = 1'b0;
    chk("pre_rst_done", 32'(done), 1);
    rst_n = 1'b0; model_reset();
    #1;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_outs", {soc_rst_n, done, led, code[28:0]}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_hold", 32'(state), 1);

    // Randomized phase
    btn_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (locked) begin if ($urandom_range(0, 299) == 0) locked = 1'b0; end
      else if ($urandom_range(0, 14) == 0) locked = 1'b1;
      if (btn_left > 0) begin btn = 1'b1; btn_left--; end
      else begin
        btn = 1'b0;
        if ($urandom_range(0, 199) == 0) btn_left = int'($urandom_range(1, 40));
      end
      ev = ($urandom_range(0, 39) == 0);
      evalue = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0; model_reset();
        tick();
        @(negedge clk) rst_n = 1'b1;
      end else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
